// File: rtl/axis_scaler_pkg.sv
// Shared definitions for the AXI-Stream scaler configuration sequencer:
// ramp FSM states, config-word field positions and the unity-gain constant.
package axis_scaler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2
    } ramp_state_t;

    localparam int SCALE_LSB  = 0;
    localparam int SCALE_MSB  = 15;
    localparam int OFFSET_LSB = 16;

    // Scaler multiplies by scale and shifts right by 15, so 0x7FFF is ~1.0.
    localparam logic signed [15:0] SCALE_UNITY = 16'sh7FFF;

    // Magnitude of a 17-bit signed difference; the range of target-scale
    // never reaches -65536, so negation cannot overflow.
    function automatic logic [16:0] abs17(input logic signed [16:0] v);
        logic signed [16:0] neg;
        neg = -v;
        return v[16] ? neg : v;
    endfunction

endpackage

// File: rtl/axis_scaler_ramp_step.sv
// Combinational single step of a scale ramp: moves scale toward target by at
// most step, landing exactly on target when it is within reach (or step is 0).
module axis_scaler_ramp_step
    import axis_scaler_pkg::*;
(
    input  logic signed [15:0] scale,
    input  logic signed [15:0] target,
    input  logic        [15:0] step,
    output logic signed [15:0] next_scale,
    output logic               reached
);

    logic signed [16:0] diff;
    logic        [16:0] mag;
    logic signed [16:0] moved;

    // Compute the distance in 17 bits and either snap to target or move one step.
    always_comb begin
        diff = $signed({target[15], target}) - $signed({scale[15], scale});
        mag  = abs17(diff);
        if (diff[16]) begin
            moved = $signed({scale[15], scale}) - $signed({1'b0, step});
        end else begin
            moved = $signed({scale[15], scale}) + $signed({1'b0, step});
        end
        if ((step == 16'd0) || (mag <= {1'b0, step})) begin
            next_scale = target;
            reached    = 1'b1;
        end else begin
            // Moving toward an in-range target keeps the result in 16 bits.
            next_scale = moved[15:0];
            reached    = 1'b0;
        end
    end

endmodule

// File: rtl/axis_scaler_ramp_ctrl.sv
// Scale/offset configuration sequencer for the AXI-Stream sample scaler.
// On start the offset field is applied at once and the scale field ramps to
// its target in bounded steps, one step per cfg_interval accepted samples.
// Optional abort input/aborted pulse: define AXIS_SCALER_RAMP_ABORT_EN.
module axis_scaler_ramp_ctrl
    import axis_scaler_pkg::*;
#(
    parameter int                 OFFSET_WIDTH = 14,
    parameter int                 CNTR_WIDTH   = 32,
    parameter logic signed [15:0] RESET_SCALE  = 16'sd0
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [31:0]           cfg_target,
    input  logic [15:0]           cfg_step,
    input  logic [CNTR_WIDTH-1:0] cfg_interval,
    input  logic                  start,
    input  logic                  sample_tick,
`ifdef AXIS_SCALER_RAMP_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    output logic [31:0]           m_cfg_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    ramp_state_t              state_reg, state_next;
    logic signed [15:0]       scale_reg, scale_next;
    logic signed [15:0]       target_reg, target_next;
    logic [OFFSET_WIDTH-1:0]  offset_reg, offset_next;
    logic [15:0]              step_reg, step_next;
    logic [CNTR_WIDTH-1:0]    interval_reg, interval_next;
    logic [CNTR_WIDTH-1:0]    cnt_reg, cnt_next;
    logic                     done_reg, done_next;
`ifdef AXIS_SCALER_RAMP_ABORT_EN
    logic                     aborted_reg, aborted_next;
`endif

    logic [CNTR_WIDTH-1:0]    start_reload;
    logic [CNTR_WIDTH-1:0]    run_reload;
    logic signed [15:0]       step_scale;
    logic                     step_reached;

    // An interval of zero is treated as one sample per step.
    assign start_reload = (cfg_interval == '0) ? CNT_ONE : cfg_interval;
    assign run_reload   = (interval_reg == '0) ? CNT_ONE : interval_reg;

    axis_scaler_ramp_step u_step (
        .scale      (scale_reg),
        .target     (target_reg),
        .step       (step_reg),
        .next_scale (step_scale),
        .reached    (step_reached)
    );

    // Next-state logic: start has priority over abort, ticks and stepping.
    always_comb begin
        state_next    = state_reg;
        scale_next    = scale_reg;
        target_next   = target_reg;
        offset_next   = offset_reg;
        step_next     = step_reg;
        interval_next = interval_reg;
        cnt_next      = cnt_reg;
        done_next     = 1'b0;
`ifdef AXIS_SCALER_RAMP_ABORT_EN
        aborted_next  = 1'b0;
`endif
        if (start) begin
            // Retargeting mid-ramp continues from the current scale value.
            target_next   = $signed(cfg_target[SCALE_MSB:SCALE_LSB]);
            offset_next   = cfg_target[OFFSET_LSB +: OFFSET_WIDTH];
            step_next     = cfg_step;
            interval_next = cfg_interval;
            cnt_next      = start_reload;
            if ($signed(cfg_target[SCALE_MSB:SCALE_LSB]) == scale_reg) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end else begin
                state_next = WAIT;
            end
        end
`ifdef AXIS_SCALER_RAMP_ABORT_EN
        else if (abort && (state_reg != IDLE)) begin
            // Freeze scale where it is; a pending step is discarded.
            state_next   = IDLE;
            aborted_next = 1'b1;
        end
`endif
        else begin
            case (state_reg)
                WAIT: begin
                    if (sample_tick) begin
                        if (cnt_reg == CNT_ONE) begin
                            state_next = STEP;
                            cnt_next   = run_reload;
                        end else begin
                            cnt_next = cnt_reg - CNT_ONE;
                        end
                    end
                end
                STEP: begin
                    scale_next = step_scale;
                    if (step_reached) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset to a muted output.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg    <= IDLE;
            scale_reg    <= RESET_SCALE;
            target_reg   <= RESET_SCALE;
            offset_reg   <= '0;
            step_reg     <= '0;
            interval_reg <= '0;
            cnt_reg      <= '0;
            done_reg     <= 1'b0;
`ifdef AXIS_SCALER_RAMP_ABORT_EN
            aborted_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            scale_reg    <= scale_next;
            target_reg   <= target_next;
            offset_reg   <= offset_next;
            step_reg     <= step_next;
            interval_reg <= interval_next;
            cnt_reg      <= cnt_next;
            done_reg     <= done_next;
`ifdef AXIS_SCALER_RAMP_ABORT_EN
            aborted_reg  <= aborted_next;
`endif
        end
    end

    // Config word assembled bit by bit straight from the field registers.
    for (genvar gi = 0; gi < 32; gi++) begin : g_cfg_bit
        if (gi <= SCALE_MSB) begin : g_scale
            assign m_cfg_data[gi] = scale_reg[gi - SCALE_LSB];
        end else if (gi < OFFSET_LSB + OFFSET_WIDTH) begin : g_offset
            assign m_cfg_data[gi] = offset_reg[gi - OFFSET_LSB];
        end else begin : g_zero
            assign m_cfg_data[gi] = 1'b0;
        end
    end

    // Target bits above the offset field carry no meaning for the scaler.
    if (OFFSET_LSB + OFFSET_WIDTH < 32) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^cfg_target[31:OFFSET_LSB + OFFSET_WIDTH];
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
`ifdef AXIS_SCALER_RAMP_ABORT_EN
    assign aborted = aborted_reg;
`endif

endmodule

// File: tb/tb_axis_scaler_ramp_ctrl.sv
// Self-checking bench for axis_scaler_ramp_ctrl: directed ramp scenarios plus
// a randomized phase, all checked against a ramp-plan reference model.
// Build with AXIS_SCALER_RAMP_ABORT_EN defined to exercise abort.
module tb_axis_scaler_ramp_ctrl;

`ifdef AXIS_SCALER_RAMP_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] cfg_target;
    logic [15:0] cfg_step;
    logic [31:0] cfg_interval;
    logic        start;
    logic        sample_tick;
    logic [31:0] m_cfg_data;
    logic        busy;
    logic        done;
`ifdef AXIS_SCALER_RAMP_ABORT_EN
    logic        abort;
    logic        aborted;
`endif

    always #5 aclk = ~aclk;

    axis_scaler_ramp_ctrl dut (
        .aclk         (aclk),
        .areset       (areset),
        .cfg_target   (cfg_target),
        .cfg_step     (cfg_step),
        .cfg_interval (cfg_interval),
        .start        (start),
        .sample_tick  (sample_tick),
`ifdef AXIS_SCALER_RAMP_ABORT_EN
        .abort        (abort),
        .aborted      (aborted),
`endif
        .m_cfg_data   (m_cfg_data),
        .busy         (busy),
        .done         (done)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a start precomputes the whole list of scale values the
    // ramp will pass through; every interval-th counted tick schedules the
    // next value, which becomes visible two cycles after that tick.
    int m_scale, m_offset, m_iv, ticks_left;
    bit m_busy, m_done, m_aborted, step_due;
    int plan[$];

    int cyc_no, done_cnt, last_done_cyc;
    logic [15:0] prev_scale;
    logic [15:0] seen[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_scale = 0; m_offset = 0; m_busy = 0; m_done = 0; m_aborted = 0;
        step_due = 0; ticks_left = 0; m_iv = 1;
        plan.delete();
    endtask

    task automatic model_cycle(input bit st, input bit tk, input bit ab,
                               input logic [31:0] tgt, input logic [15:0] stp,
                               input logic [31:0] iv);
        int t, s, d, ad;
        m_done = 0;
        m_aborted = 0;
        if (st) begin
            m_offset = int'(tgt[29:16]);
            t = int'($signed(tgt[15:0]));
            plan.delete();
            s = m_scale;
            while (s != t) begin
                d  = t - s;
                ad = (d < 0) ? -d : d;
                if (stp == 0 || ad <= int'(stp)) s = t;
                else s = s + ((d > 0) ? int'(stp) : -int'(stp));
                plan.push_back(s);
            end
            m_iv = (iv == 0) ? 1 : int'(iv);
            ticks_left = m_iv;
            step_due = 0;
            if (plan.size() == 0) begin
                m_busy = 0;
                m_done = 1;
            end else begin
                m_busy = 1;
            end
            $display("start target=%0d offset=%0h step=%0d interval=%0d steps=%0d",
                     t, m_offset, stp, iv, plan.size());
        end else if (ABORT_ON && ab && m_busy) begin
            m_busy = 0;
            m_aborted = 1;
            step_due = 0;
            plan.delete();
        end else if (m_busy) begin
            if (step_due) begin
                m_scale = plan.pop_front();
                step_due = 0;
                if (plan.size() == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (tk) begin
                ticks_left--;
                if (ticks_left == 0) begin
                    step_due = 1;
                    ticks_left = m_iv;
                end
            end
        end
    endtask

    // One clock cycle: drive, advance the model, then compare after the edge.
    task automatic cyc(input bit st, input bit tk, input bit ab);
        start = st;
        sample_tick = tk;
`ifdef AXIS_SCALER_RAMP_ABORT_EN
        abort = ab;
`endif
        if (!st) begin
            cfg_target   = $urandom;
            cfg_step     = 16'($urandom);
            cfg_interval = $urandom;
        end
        model_cycle(st, tk, ab, cfg_target, cfg_step, cfg_interval);
        @(posedge aclk);
        #1;
        cyc_no++;
        check_val("cfg_word", m_cfg_data, {2'b00, 14'(m_offset), 16'(m_scale)});
        check_val("busy", {31'b0, busy}, {31'b0, m_busy});
        check_val("done", {31'b0, done}, {31'b0, m_done});
`ifdef AXIS_SCALER_RAMP_ABORT_EN
        check_val("aborted", {31'b0, aborted}, {31'b0, m_aborted});
`endif
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc_no;
        end
        if (m_cfg_data[15:0] != prev_scale) begin
            seen.push_back(m_cfg_data[15:0]);
            prev_scale = m_cfg_data[15:0];
        end
        start = 1'b0;
        sample_tick = 1'b0;
`ifdef AXIS_SCALER_RAMP_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    task automatic issue(input int tgt_scale, input int off, input int stp, input int iv, input bit tk);
        cfg_target   = {2'b00, 14'(off), 16'(tgt_scale)};
        cfg_step     = 16'(stp);
        cfg_interval = 32'(iv);
        cyc(1'b1, tk, 1'b0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        start = 1'b0;
        sample_tick = 1'b0;
`ifdef AXIS_SCALER_RAMP_ABORT_EN
        abort = 1'b0;
`endif
        @(posedge aclk);
        #1;
        areset = 1'b0;
        model_reset();
        prev_scale = 16'h0000;
        check_val("rst_cfg_word", m_cfg_data, 32'h0);
        check_val("rst_busy", {31'b0, busy}, 32'h0);
        check_val("rst_done", {31'b0, done}, 32'h0);
    endtask

    task automatic run_to_end(input int max_cycles);
        for (int i = 0; i < max_cycles && m_busy; i++) cyc(1'b0, 1'b1, 1'b0);
        check_val("ramp_end_busy", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        int s0;
        int exp_seq[4];
        int exp_rt[3];
        bit st, tk, ab;
        int r, delta;

        areset = 1'b1;
        start = 1'b0;
        sample_tick = 1'b0;
        cfg_target = '0;
        cfg_step = '0;
        cfg_interval = '0;
`ifdef AXIS_SCALER_RAMP_ABORT_EN
        abort = 1'b0;
`endif
        cyc_no = 0;
        done_cnt = 0;
        last_done_cyc = 0;
        model_reset();
        repeat (2) @(posedge aclk);
        do_reset();

        // 0 -> 1000, step 300, interval 4, tick every cycle (start tick ignored).
        seen.delete();
        done_cnt = 0;
        s0 = cyc_no;
        issue(1000, 0, 300, 4, 1'b1);
        run_to_end(60);
        exp_seq = '{300, 600, 900, 1000};
        check_val("ramp_seq_len", 32'(seen.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            check_val($sformatf("ramp_seq%0d", i), {16'h0, seen[i]}, {16'h0, 16'(exp_seq[i])});
        check_val("ramp_done_cnt", 32'(done_cnt), 32'd1);
        check_val("ramp_done_latency", 32'(last_done_cyc - s0), 32'd21);

        // 1000 -> -500 with step 0: one jump after the interval.
        seen.delete();
        done_cnt = 0;
        issue(-500, 0, 0, 3, 1'b0);
        run_to_end(30);
        check_val("jump_len", 32'(seen.size()), 32'd1);
        if (seen.size() > 0) check_val("jump_val", {16'h0, seen[0]}, {16'h0, 16'hFE0C});
        check_val("jump_done_cnt", 32'(done_cnt), 32'd1);

        // Target equal to current scale: done next cycle, never busy.
        issue(-500, 5, 77, 3, 1'b1);
        check_val("eq_done", {31'b0, done}, 32'd1);
        check_val("eq_busy", {31'b0, busy}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0);

        // Offset applied at start, scale held until the first step.
        issue(100, 14'h1F00, 400, 2, 1'b0);
        check_val("offset_at_start", {18'h0, m_cfg_data[29:16]}, 32'h1F00);
        check_val("scale_held", {16'h0, m_cfg_data[15:0]}, {16'h0, 16'hFE0C});
        run_to_end(40);

        // Retarget at 600 with start and tick in the same cycle.
        issue(1000, 0, 250, 1, 1'b1);
        for (int i = 0; i < 40 && m_scale != 600; i++) cyc(1'b0, 1'b1, 1'b0);
        seen.delete();
        done_cnt = 0;
        issue(0, 0, 200, 2, 1'b1);
        run_to_end(40);
        exp_rt = '{400, 200, 0};
        check_val("retgt_len", 32'(seen.size()), 32'd3);
        for (int i = 0; i < 3 && i < seen.size(); i++)
            check_val($sformatf("retgt%0d", i), {16'h0, seen[i]}, {16'h0, 16'(exp_rt[i])});
        check_val("retgt_done_cnt", 32'(done_cnt), 32'd1);

        // Interval 0 behaves as 1.
        issue(50, 0, 10, 0, 1'b0);
        run_to_end(30);

        // No ticks: no progress; then reset mid-ramp.
        issue(500, 0, 100, 2, 1'b0);
        repeat (30) cyc(1'b0, 1'b0, 1'b0);
        check_val("stall_busy", {31'b0, busy}, 32'd1);
        check_val("stall_scale", {16'h0, m_cfg_data[15:0]}, 32'd50);
        repeat (4) cyc(1'b0, 1'b1, 1'b0);
        done_cnt = 0;
        do_reset();
        cyc(1'b0, 1'b0, 1'b0);
        check_val("rst_mid_no_done", 32'(done_cnt), 32'd0);

`ifdef AXIS_SCALER_RAMP_ABORT_EN
        // Abort at 600 freezes the scale; abort while idle is ignored.
        done_cnt = 0;
        issue(1000, 0, 300, 2, 1'b0);
        for (int i = 0; i < 40 && m_scale != 600; i++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        check_val("abort_pulse", {31'b0, aborted}, 32'd1);
        check_val("abort_scale", {16'h0, m_cfg_data[15:0]}, 32'd600);
        repeat (5) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        check_val("abort_idle", {31'b0, aborted}, 32'd0);
        check_val("abort_no_done", 32'(done_cnt), 32'd0);
`endif

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom_range(0, 29) == 0);
            tk = ($urandom_range(0, 99) < 60);
            ab = ($urandom_range(0, 49) == 0);
            if (st) begin
                r = $urandom_range(0, 3);
                delta = $urandom_range(0, 6000) - 3000;
                cfg_target[31:30] = 2'($urandom);
                cfg_target[29:16] = 14'($urandom);
                if (r == 0) cfg_target[15:0] = 16'(m_scale);
                else if (r == 1) cfg_target[15:0] = 16'($urandom);
                else cfg_target[15:0] = 16'(m_scale + delta);
                cfg_step = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 3000));
                cfg_interval = $urandom_range(0, 4);
            end
            cyc(st, tk, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
